// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - RV64I multi-cycle control FSM with memory-ready wait and sticky fault trap
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_arstn,
    input  logic [6:0] i_op,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_adr_src,
    output logic       o_instr_we,
    output logic       o_pc_we,
    output logic       o_branch,
    output logic       o_reg_we,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [2:0] o_alu_op,
    output logic [2:0] o_result_src,
    output logic       o_illegal
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR_CALC, S_JUMP, S_LUI, S_AUIPC, S_FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_IW     = 7'b0011011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_count;
    logic          mem_state;
    logic          timed_out;
    logic          w_op;

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timed_out = mem_state && !i_mem_ready && (wait_count == TO_MAX);
    assign w_op      = (i_op == OP_RW) || (i_op == OP_IW);

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Any state change clears the counter, so each memory state starts its wait from zero.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            wait_count <= '0;
        end else if (state_next != state) begin
            wait_count <= '0;
        end else if (mem_state && !i_mem_ready && (wait_count != TO_MAX)) begin
            wait_count <= wait_count + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH: begin
                if (i_mem_ready)    state_next = S_DECODE;
                else if (timed_out) state_next = S_FAULT;
            end
            S_DECODE: begin
                case (i_op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R, OP_RW:       state_next = S_EXEC_R;
                    OP_I, OP_IW:       state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JUMP;
                    OP_JALR:           state_next = S_JALR_CALC;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_FAULT;
                endcase
            end
            S_MEMADR: state_next = (i_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (i_mem_ready)    state_next = S_MEMWB;
                else if (timed_out) state_next = S_FAULT;
            end
            S_MEMWRITE: begin
                if (i_mem_ready)    state_next = S_FETCH;
                else if (timed_out) state_next = S_FAULT;
            end
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_LUI, S_AUIPC: state_next = S_FETCH;
            S_EXEC_R, S_EXEC_I: state_next = S_ALUWB;
            S_JALR_CALC:        state_next = S_JUMP;
            S_FAULT:            state_next = S_FAULT;
            default:            state_next = S_FAULT;
        endcase
    end

    always_comb begin
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_adr_src    = 1'b0;
        o_instr_we   = 1'b0;
        o_pc_we      = 1'b0;
        o_branch     = 1'b0;
        o_reg_we     = 1'b0;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 3'b000;
        o_result_src = 3'b000;
        o_illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = 2'b10;
                o_instr_we  = i_mem_ready;
                o_pc_we     = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_MEMADR, S_JALR_CALC: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                o_mem_req = 1'b1;
                o_adr_src = 1'b1;
            end
            S_MEMWB: begin
                o_reg_we     = 1'b1;
                o_result_src = 3'b001;
            end
            S_MEMWRITE: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                o_adr_src = 1'b1;
            end
            S_EXEC_R: begin
                o_alu_src_a = 2'b10;
                o_alu_op    = w_op ? 3'b011 : 3'b010;
            end
            S_EXEC_I: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                o_alu_op    = w_op ? 3'b011 : 3'b010;
            end
            S_ALUWB: o_reg_we = 1'b1;
            // Branch target was latched into ALUOut during DECODE.
            S_BRANCH: begin
                o_alu_src_a  = 2'b10;
                o_alu_op     = 3'b001;
                o_branch     = 1'b1;
                o_result_src = 3'b011;
            end
            S_JUMP: begin
                o_pc_we      = 1'b1;
                o_reg_we     = 1'b1;
                o_result_src = 3'b010;
            end
            S_LUI: begin
                o_reg_we     = 1'b1;
                o_result_src = 3'b100;
            end
            S_AUIPC: begin
                o_reg_we     = 1'b1;
                o_result_src = 3'b011;
            end
            S_FAULT: o_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
